// File: rtl/bf16_pkg.sv
// Shared widths, default multiplier latency and a constant-safe clog2 for
// the bf16 multiplier arbiter slice.
package bf16_pkg;

  localparam int BF16_W       = 16;
  localparam int MULT_LAT_DEF = 4;

  // Minimum result is 1 so a single-entry index still gets a real bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/bf16_tag_pipe.sv
// Valid/id delay line that runs alongside the multiplier so each result
// carries its owner; valids clear on reset, ids need no reset.
module bf16_tag_pipe #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  input  logic [ID_W-1:0] in_id,
  output logic            out_vld,
  output logic [ID_W-1:0] out_id
);

  logic [DEPTH-1:0] vld_sr;
  logic [ID_W-1:0]  id_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) vld_sr <= '0;
    else     vld_sr <= {vld_sr[DEPTH-2:0], in_vld};
  end

  always_ff @(posedge clk) begin
    id_sr[0] <= in_id;
    for (int i = 1; i < DEPTH; i++) id_sr[i] <= id_sr[i-1];
  end

  assign out_vld = vld_sr[DEPTH-1];
  assign out_id  = id_sr[DEPTH-1];

endmodule

// File: rtl/bfloat16_mult.sv
// Pipelined bf16 multiplier, round-to-nearest-even, subnormals flushed to zero.
// Result appears LAT cycles after the operands are presented; no stall input.
module bfloat16_mult
  import bf16_pkg::*;
#(
  parameter int LAT = MULT_LAT_DEF
) (
  input  logic              clk,
  input  logic [BF16_W-1:0] a,
  input  logic [BF16_W-1:0] b,
  output logic [BF16_W-1:0] p
);

  logic              sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, rnd;
  logic [15:0]       prod;
  logic [9:0]        e_b;
  logic [6:0]        mant;
  logic              guard, sticky;
  logic [16:0]       er;
  logic [BF16_W-1:0] p_c;
  logic [BF16_W-1:0] stg [LAT];

  always_comb begin
    sgn    = a[15] ^ b[15];
    a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
    b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
    a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'd0);
    b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'd0);
    a_zero = (a[14:7] == 8'h00);
    b_zero = (b[14:7] == 8'h00);
    prod   = {1'b1, a[6:0]} * {1'b1, b[6:0]};
    // Exponent kept with a +127 bias so the whole path stays unsigned.
    e_b    = 10'(a[14:7]) + 10'(b[14:7]) + 10'(prod[15]);
    if (prod[15]) begin
      mant   = prod[14:8];
      guard  = prod[7];
      sticky = |prod[6:0];
    end else begin
      mant   = prod[13:7];
      guard  = prod[6];
      sticky = |prod[5:0];
    end
    rnd = guard && (sticky || mant[0]);
    er  = {e_b, mant} + 17'(rnd);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      p_c = 16'h7FC0;
    else if (a_inf || b_inf)
      p_c = {sgn, 8'hFF, 7'd0};
    else if (a_zero || b_zero || er[16:7] <= 10'd127)
      p_c = {sgn, 15'd0};
    else if (er[16:7] >= 10'd382)
      p_c = {sgn, 8'hFF, 7'd0};
    else
      p_c = {sgn, 8'(er[16:7] - 10'd127), er[6:0]};
  end

  always_ff @(posedge clk) begin
    stg[0] <= p_c;
    for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
  end

  assign p = stg[LAT-1];

endmodule

// File: rtl/bf16_mult_arbiter.sv
// Round-robin share of one pipelined bf16 multiplier among NREQ requesters.
// Grant is combinational; results stream out MULT_LAT cycles later, no back-pressure.
module bf16_mult_arbiter
  import bf16_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int ID_W     = clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*BF16_W-1:0] req_a,
  input  logic [NREQ*BF16_W-1:0] req_b,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   hold,
  output logic                   res_valid,
  output logic [ID_W-1:0]        res_id,
  output logic [BF16_W-1:0]      res_data,
  output logic                   busy
);

  localparam int CNT_W = clog2(MULT_LAT + 1);

  logic [ID_W-1:0]   ptr, gnt_id;
  logic              gnt_any, issue;
  logic [BF16_W-1:0] mult_a, mult_b;
  logic [CNT_W-1:0]  inflight;
  int                idx;

  // Cyclic search starting at ptr; first valid requester wins.
  always_comb begin
    req_ready = '0;
    gnt_id    = '0;
    gnt_any   = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
    if (gnt_any && !hold && !rst) req_ready[gnt_id] = 1'b1;
  end

  assign issue  = |req_ready;
  assign mult_a = issue ? req_a[gnt_id*BF16_W +: BF16_W] : '0;
  assign mult_b = issue ? req_b[gnt_id*BF16_W +: BF16_W] : '0;

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (issue)
      ptr <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + ID_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      inflight <= '0;
    else if (issue && !res_valid)
      inflight <= inflight + CNT_W'(1);
    else if (!issue && res_valid)
      inflight <= inflight - CNT_W'(1);
  end

  assign busy = |inflight;

  bfloat16_mult #(.LAT(MULT_LAT)) u_mult (
    .clk (clk),
    .a   (mult_a),
    .b   (mult_b),
    .p   (res_data)
  );

  bf16_tag_pipe #(.DEPTH(MULT_LAT), .ID_W(ID_W)) u_tag (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (issue),
    .in_id   (gnt_id),
    .out_vld (res_valid),
    .out_id  (res_id)
  );

endmodule

// File: tb/tb_bf16_mult_arbiter.sv
// Scoreboard bench: a reference arbiter and real-arithmetic bf16 model
// predict grants, busy and each result with its due cycle.
module tb_bf16_mult_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req_valid;
  logic [63:0]     req_a, req_b;
  logic [3:0]      req_ready;
  logic            hold;
  logic            res_valid;
  logic [1:0]      res_id;
  logic [15:0]     res_data;
  logic            busy;

  bf16_mult_arbiter #(.NREQ(NREQ), .MULT_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .hold      (hold),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic armed = 1'b0;
  int   m_ptr = 0;
  int   m_inflight = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic real bf2r(input logic [15:0] x);
    logic [63:0] d;
    d = {x[15], 11'(x[14:7]) - 11'd127 + 11'd1023, x[6:0], 45'd0};
    return $bitstoreal(d);
  endfunction

  // Product of two 8-bit significands is exact in a double; round it to bf16.
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    real         p;
    logic [63:0] d;
    logic [44:0] rem, half;
    logic [6:0]  m;
    logic [14:0] r;
    int          e;
    logic        up;
    if (a[14:7] == 8'd0 || b[14:7] == 8'd0) return {a[15] ^ b[15], 15'd0};
    p    = bf2r(a) * bf2r(b);
    d    = $realtobits(p);
    e    = int'(d[62:52]) - 1023 + 127;
    m    = d[51:45];
    rem  = d[44:0];
    half = 45'd1 << 44;
    up   = (rem > half) || (rem == half && m[0]);
    r    = {8'(e), m} + 15'(up);
    return {d[63], r};
  endfunction

  function automatic logic [3:0] exp_grant(input logic [3:0] v, input int ptr,
                                           input logic h, input logic r);
    int i;
    if (h || r) return 4'd0;
    for (int k = 0; k < NREQ; k++) begin
      i = (ptr + k) % NREQ;
      if (v[i]) return 4'(1 << i);
    end
    return 4'd0;
  endfunction

  function automatic logic [15:0] rand_bf16();
    logic [15:0] x;
    x[15]   = 1'($urandom_range(0, 1));
    x[14:7] = 8'($urandom_range(112, 142));
    x[6:0]  = 7'($urandom_range(0, 127));
    if ($urandom_range(0, 15) == 0) x[14:0] = 15'd0;
    return x;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) armed <= 1'b1;
  end

  always @(negedge clk) begin
    logic       exp_rv;
    logic [3:0] eg;
    int         gid;
    if (armed) begin
      exp_rv = (sb.size() > 0) && (sb[0].due == cyc);
      check_val("res_valid", 32'(res_valid), 32'(exp_rv));
      if (exp_rv) begin
        check_val("res_id", 32'(res_id), 32'(sb[0].id));
        check_val("res_data", 32'(res_data), 32'(sb[0].data));
      end
      eg = exp_grant(req_valid, m_ptr, hold, rst);
      check_val("req_ready", 32'(req_ready), 32'(eg));
      check_val("busy", 32'(busy), 32'(m_inflight != 0));
      if (rst) begin
        sb.delete();
        m_ptr      = 0;
        m_inflight = 0;
      end else begin
        if (exp_rv) void'(sb.pop_front());
        if (eg != 4'd0) begin
          gid = 0;
          for (int i = 0; i < NREQ; i++) if (eg[i]) gid = i;
          sb.push_back('{2'(gid), ref_mul(req_a[gid*16 +: 16], req_b[gid*16 +: 16]), cyc + LAT});
          m_ptr = (gid + 1) % NREQ;
        end
        m_inflight = m_inflight + ((eg != 4'd0) ? 1 : 0) - (exp_rv ? 1 : 0);
      end
    end
  end

  task automatic drive(input logic [3:0] v, input logic h, input logic r, input int n);
    repeat (n) begin
      rst       = r;
      hold      = h;
      req_valid = v;
      for (int i = 0; i < NREQ; i++) begin
        req_a[i*16 +: 16] = rand_bf16();
        req_b[i*16 +: 16] = rand_bf16();
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    req_a = '0;
    req_b = '0;
    // Reset with every requester asking.
    drive(4'hF, 1'b0, 1'b1, 3);
    drive(4'h0, 1'b0, 1'b0, 2);

    // Single issue from requester 2: 1.0 * 2.0.
    rst       = 1'b0;
    hold      = 1'b0;
    req_valid = 4'b0100;
    req_a[47:32] = 16'h3F80;
    req_b[47:32] = 16'h4000;
    @(posedge clk);
    #1;
    drive(4'h0, 1'b0, 1'b0, 6);

    // Full contention, back-to-back issue.
    drive(4'hF, 1'b0, 1'b0, 8);
    drive(4'h0, 1'b0, 1'b0, 6);

    // Move ptr to 2, then requesters 1 and 3 contend.
    drive(4'b0010, 1'b0, 1'b0, 1);
    drive(4'h0, 1'b0, 1'b0, 5);
    drive(4'b1010, 1'b0, 1'b0, 2);
    drive(4'h0, 1'b0, 1'b0, 6);

    // Hold right after one issue.
    drive(4'b0001, 1'b0, 1'b0, 1);
    drive(4'hF, 1'b1, 1'b0, 5);
    drive(4'h0, 1'b0, 1'b0, 3);

    // Reset with three operations in flight.
    drive(4'hF, 1'b0, 1'b0, 3);
    drive(4'h0, 1'b0, 1'b1, 1);
    drive(4'h0, 1'b0, 1'b0, 6);

    // Random mixed traffic with occasional hold.
    for (int n = 0; n < 40; n++)
      drive(4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0), 1'b0, 1);
    drive(4'h0, 1'b0, 1'b0, 8);

    check_val("drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
